// File: rtl/vlsu_hold_req.sv
// Vector load/store sequencer: issues a strided multi-beat memory operation,
// writes load beats into the VRF and raises the pipeline hold request.
module vlsu_hold_req #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned MAX_OUT = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              issue_valid_i,
   output logic              issue_ready_o,
   input  logic              issue_is_store_i,
   input  logic [ADDR_W-1:0] issue_base_i,
   input  logic [ADDR_W-1:0] issue_stride_i,
   input  logic [CNT_W-1:0]  issue_nbeats_i,
   input  logic [3:0]        hold_ctrl_i,
   output logic [3:0]        hold_req_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic [DATA_W-1:0] st_data_i,
   output logic              st_data_pop_o,
   output logic              vrf_we_o,
   output logic [CNT_W-1:0]  vrf_idx_o,
   output logic [DATA_W-1:0] vrf_wdata_o,
   output logic              done_o
);

   localparam logic [3:0] MAX_OUT_L = 4'(MAX_OUT);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic              is_store_q;
   logic [ADDR_W-1:0] stride_q;
   logic [ADDR_W-1:0] addr_q;
   logic [CNT_W-1:0]  nbeats_q;
   logic [CNT_W-1:0]  issued_q;
   logic [CNT_W-1:0]  resp_q;
   logic [3:0]        outst_q, outst_d;

   logic accept;
   logic in_issue;
   logic busy;
   logic req;
   logic grant;
   logic rsp;
   logic last_grant;

   // Only the VLSU hold bit affects this block.
   logic unused_hold;
   assign unused_hold = ^hold_ctrl_i[2:0];

   assign accept     = (state_q == IDLE) & issue_valid_i;
   assign in_issue   = (state_q == ISSUE);
   assign busy       = (state_q != IDLE);
   assign req        = in_issue & ~hold_ctrl_i[3] & (is_store_q | (outst_q < MAX_OUT_L));
   assign grant      = req & mem_gnt_i;
   assign rsp        = mem_rvalid_i & ~is_store_q & ((state_q == ISSUE) | (state_q == DRAIN));
   assign last_grant = grant & (issued_q == (nbeats_q - 1'b1));

   // A grant and a response in the same cycle cancel out.
   always_comb begin
      outst_d = outst_q;
      if (grant & ~is_store_q & ~rsp) begin
         outst_d = outst_q + 4'd1;
      end else if (rsp & ~(grant & ~is_store_q) & (outst_q != 4'd0)) begin
         outst_d = outst_q - 4'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (issue_valid_i) begin
               state_d = (issue_nbeats_i == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            if (last_grant) begin
               state_d = is_store_q ? DONE : DRAIN;
            end
         end
         DRAIN: begin
            if (outst_d == 4'd0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         is_store_q <= 1'b0;
         stride_q   <= '0;
         addr_q     <= '0;
         nbeats_q   <= '0;
         issued_q   <= '0;
         resp_q     <= '0;
         outst_q    <= '0;
      end else if (accept) begin
         is_store_q <= issue_is_store_i;
         stride_q   <= issue_stride_i;
         addr_q     <= issue_base_i;
         nbeats_q   <= issue_nbeats_i;
         issued_q   <= '0;
         resp_q     <= '0;
         outst_q    <= '0;
      end else begin
         outst_q <= outst_d;
         if (grant) begin
            addr_q   <= addr_q + stride_q;
            issued_q <= issued_q + 1'b1;
         end
         if (rsp) begin
            resp_q <= resp_q + 1'b1;
         end
      end
   end

   assign issue_ready_o = (state_q == IDLE);
   assign done_o        = (state_q == DONE);
   assign hold_req_o    = {1'b0, ~is_store_q & ((state_q == ISSUE) | (state_q == DRAIN)), busy, busy};

   assign mem_req_o     = req;
   assign mem_we_o      = in_issue & is_store_q;
   assign mem_addr_o    = in_issue ? addr_q : '0;
   assign mem_wdata_o   = (in_issue & is_store_q) ? st_data_i : '0;
   assign st_data_pop_o = grant & is_store_q;

   assign vrf_we_o      = rsp;
   assign vrf_idx_o     = rsp ? resp_q : '0;
   assign vrf_wdata_o   = rsp ? mem_rdata_i : '0;

endmodule

// File: tb/tb_vlsu_hold_req.sv
// Self-checking bench for vlsu_hold_req: table of ops driven through a
// cycle-level memory model with scoreboard queues, plus a reset-in-DRAIN sequence.
module tb_vlsu_hold_req;

   localparam int MAXO = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic        issue_valid_i, issue_ready_o, issue_is_store_i;
   logic [31:0] issue_base_i, issue_stride_i;
   logic [7:0]  issue_nbeats_i;
   logic [3:0]  hold_ctrl_i, hold_req_o;
   logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i, st_data_i;
   logic        st_data_pop_o, vrf_we_o, done_o;
   logic [7:0]  vrf_idx_o;
   logic [31:0] vrf_wdata_o;

   vlsu_hold_req #(.ADDR_W(32), .DATA_W(32), .CNT_W(8), .MAX_OUT(MAXO)) dut (
      .clk(clk), .rstn(rstn),
      .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
      .issue_is_store_i(issue_is_store_i), .issue_base_i(issue_base_i),
      .issue_stride_i(issue_stride_i), .issue_nbeats_i(issue_nbeats_i),
      .hold_ctrl_i(hold_ctrl_i), .hold_req_o(hold_req_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i), .st_data_i(st_data_i), .st_data_pop_o(st_data_pop_o),
      .vrf_we_o(vrf_we_o), .vrf_idx_o(vrf_idx_o), .vrf_wdata_o(vrf_wdata_o),
      .done_o(done_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_store;
      logic [31:0] base;
      logic [31:0] stride;
      logic [7:0]  n;
      int          lat;       // load response latency in cycles after grant
      bit          rnd_gnt;   // random grant instead of grant every cycle
      int          hold_at;   // offset of a 2-cycle VLSU hold pulse, 0 = none
      int          exp_done;  // expected done_o offset after accept, 0 = unchecked
   } op_t;

   typedef struct { logic [31:0] addr; logic we; } beat_t;
   typedef struct { logic [7:0] idx; logic [31:0] data; } vrf_t;
   typedef struct { int due; logic [31:0] data; } rsp_t;

   beat_t beat_q[$];
   vrf_t  vrf_q[$];
   rsp_t  rsp_q[$];
   op_t   ops[9];

   int passed = 0;
   int total  = 0;
   int pops   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ldata(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic run_op(input op_t op);
      int ofs;
      int granted   = 0;
      int responded = 0;
      int outst     = 0;
      int exp_done  = (op.n == 0) ? 1 : -1;
      bit hold, is_done, in_issue, hs;
      beat_t b;
      vrf_t  v;
      rsp_t  r;

      beat_q.delete(); vrf_q.delete(); rsp_q.delete();
      for (int i = 0; i < int'(op.n); i++) begin
         b.addr = op.base + op.stride * i;
         b.we   = op.is_store;
         beat_q.push_back(b);
         if (!op.is_store) begin
            v.idx  = 8'(i);
            v.data = ldata(b.addr);
            vrf_q.push_back(v);
         end
      end

      issue_valid_i    = 1'b1;
      issue_is_store_i = op.is_store;
      issue_base_i     = op.base;
      issue_stride_i   = op.stride;
      issue_nbeats_i   = op.n;
      #1;
      chk("ready_before_accept", issue_ready_o, 1'b1);
      step();
      issue_valid_i = 1'b0;

      for (ofs = 1; ofs <= 300; ofs++) begin
         hold         = (op.hold_at != 0) && ofs >= op.hold_at && ofs < op.hold_at + 2;
         hold_ctrl_i  = {hold, 3'b101};
         mem_gnt_i    = op.rnd_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
         st_data_i    = 32'h5A00_0000 + pops;
         mem_rvalid_i = (rsp_q.size() != 0) && (rsp_q[0].due <= ofs);
         mem_rdata_i  = mem_rvalid_i ? rsp_q[0].data : 32'h0;
         #1;
         in_issue = granted < int'(op.n);
         is_done  = (ofs == exp_done);
         chk("hold_req", hold_req_o, {1'b0, !op.is_store && !is_done, 2'b11});
         chk("done", done_o, is_done);
         chk("ready_busy", issue_ready_o, 1'b0);
         chk("mem_req", mem_req_o, in_issue && !hold && (op.is_store || outst < MAXO));
         if (in_issue) begin
            chk("mem_addr", mem_addr_o, beat_q[0].addr);
            chk("mem_we", mem_we_o, op.is_store);
         end
         chk("vrf_we", vrf_we_o, mem_rvalid_i);
         if (mem_rvalid_i && vrf_q.size() != 0) begin
            v = vrf_q.pop_front();
            chk("vrf_idx", vrf_idx_o, v.idx);
            chk("vrf_wdata", vrf_wdata_o, v.data);
         end
         hs = mem_req_o && mem_gnt_i;
         chk("st_pop", st_data_pop_o, hs && op.is_store);
         if (hs && beat_q.size() != 0) begin
            b = beat_q.pop_front();
            granted++;
            if (op.is_store) begin
               chk("st_wdata", mem_wdata_o, st_data_i);
               pops++;
               if (granted == int'(op.n)) exp_done = ofs + 1;
            end else begin
               r.due  = ofs + op.lat;
               r.data = ldata(b.addr);
               rsp_q.push_back(r);
               outst++;
            end
         end
         if (mem_rvalid_i) begin
            void'(rsp_q.pop_front());
            outst--;
            responded++;
            if (responded == int'(op.n)) exp_done = ofs + 1;
         end
         if (is_done) break;
         step();
      end
      chk("op_timeout", ofs > 300, 1'b0);
      if (op.exp_done != 0) chk("done_offset", ofs, op.exp_done);

      step();
      hold_ctrl_i  = 4'b0;
      mem_rvalid_i = 1'b0;
      #1;
      chk("ready_after", issue_ready_o, 1'b1);
      chk("hold_after", hold_req_o, 4'b0000);
      chk("beats_left", beat_q.size(), 0);
      chk("vrf_left", vrf_q.size(), 0);
   endtask

   initial begin
      ops[0] = '{1'b1, 32'h100, 32'h4,        8'd3, 0, 1'b0, 0, 4};
      ops[1] = '{1'b0, 32'h400, 32'h4,        8'd6, 3, 1'b0, 0, 10};
      ops[2] = '{1'b0, 32'h800, 32'h10,       8'd6, 3, 1'b0, 3, 12};
      ops[3] = '{1'b0, 32'hA00, 32'h4,        8'd6, 6, 1'b0, 0, 16};
      ops[4] = '{1'b1, 32'h4,   32'hFFFFFFFC, 8'd3, 0, 1'b0, 0, 4};
      ops[5] = '{1'b0, 32'hC00, 32'h4,        8'd0, 0, 1'b0, 0, 1};
      ops[6] = '{1'b0, 32'hD00, 32'h8,        8'd4, 1, 1'b0, 0, 6};
      ops[7] = '{1'b0, 32'hE00, 32'h4,        8'd5, 2, 1'b1, 0, 0};
      ops[8] = '{1'b1, 32'hF00, 32'h20,       8'd4, 0, 1'b1, 0, 0};

      rstn = 1'b0;
      issue_valid_i = 1'b0; issue_is_store_i = 1'b0; issue_base_i = '0;
      issue_stride_i = '0; issue_nbeats_i = '0; hold_ctrl_i = '0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; st_data_i = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", issue_ready_o, 1'b1);
      chk("rst_hold", hold_req_o, 4'b0000);
      chk("rst_req", mem_req_o, 1'b0);
      chk("rst_done", done_o, 1'b0);
      rstn = 1'b1;
      step();

      foreach (ops[i]) run_op(ops[i]);

      // Reset while draining a 2-beat load: late responses must be dropped.
      issue_valid_i = 1'b1; issue_is_store_i = 1'b0;
      issue_base_i = 32'h200; issue_stride_i = 32'h8; issue_nbeats_i = 8'd2;
      mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0;
      step();
      issue_valid_i = 1'b0;
      chk("rd_req1", mem_req_o, 1'b1);
      chk("rd_addr1", mem_addr_o, 32'h200);
      step();
      chk("rd_addr2", mem_addr_o, 32'h208);
      step();
      chk("rd_hold_drain", hold_req_o, 4'b0111);
      chk("rd_req_drain", mem_req_o, 1'b0);
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBEEF;
      #1;
      chk("rd_ready", issue_ready_o, 1'b1);
      chk("rd_hold", hold_req_o, 4'b0000);
      chk("rd_vrf_we", vrf_we_o, 1'b0);
      chk("rd_done", done_o, 1'b0);
      chk("rd_mem_req", mem_req_o, 1'b0);
      chk("rd_mem_addr", mem_addr_o, 32'h0);
      step();
      chk("rd_vrf_we2", vrf_we_o, 1'b0);
      mem_rvalid_i = 1'b0;
      step();

      run_op(ops[0]);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/vlsu_hold_req.md
# vlsu_hold_req

Vector load/store sequencer that issues a strided multi-beat memory operation and generates the 4-bit hold request consumed by the pipeline hold controller. It sits between the vector decoder and the memory port. It produces the request (`hold_req_o`, wired to the controller's VID/VLSU request input) and obeys the controller's `hold_ctrl` output in return. Load beats are written straight into the vector register file write port.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `CNT_W`, 8: beat-count width.
- `MAX_OUT`, 4: maximum outstanding load beats (2..15).

- `clk`, in, 1: clock, rising edge.
- `rstn`, in, 1: reset, synchronous, active-low.
- `issue_valid_i`, in, 1: decoded vector memory op valid.
- `issue_ready_o`, out, 1: sequencer idle; accepts an op when this and `issue_valid_i` are both high.
- `issue_is_store_i`, in, 1: 1 = store, 0 = load.
- `issue_base_i`, in, `ADDR_W`: first beat address.
- `issue_stride_i`, in, `ADDR_W`: byte stride between beats.
- `issue_nbeats_i`, in, `CNT_W`: beat count (0 allowed).
- `hold_ctrl_i`, in, 4: controller hold vector, [3]=VLSU, [2]=VEX, [1]=VID, [0]=PC.
- `hold_req_o`, out, 4: hold request to the controller, same bit map.
- `mem_req_o`, out, 1: memory request.
- `mem_we_o`, out, 1: write enable (store).
- `mem_addr_o`, out, `ADDR_W`: beat address.
- `mem_wdata_o`, out, `DATA_W`: store data, equal to `st_data_i`.
- `mem_gnt_i`, in, 1: request accepted this cycle.
- `mem_rvalid_i`, in, 1: load response valid.
- `mem_rdata_i`, in, `DATA_W`: load response data.
- `st_data_i`, in, `DATA_W`: head of store data queue.
- `st_data_pop_o`, out, 1: pop store queue.
- `vrf_we_o`, out, 1: VRF element write.
- `vrf_idx_o`, out, `CNT_W`: element index.
- `vrf_wdata_o`, out, `DATA_W`: element data.
- `done_o`, out, 1: one-cycle completion pulse.

## Operation
- States:
  - IDLE: accept an op.
  - ISSUE: send beats.
  - DRAIN: wait for load responses.
  - DONE: completion cycle, then return to IDLE.
- Accept in IDLE when `issue_valid_i` is high.
  - Latch `is_store`, `base`, `stride` and `nbeats`.
  - Clear the counters: `addr` = base, `issued` = 0, `resp` = 0, `outst` = 0.
  - Next state is ISSUE, or DONE if `nbeats` = 0.
- In ISSUE:
  - `mem_req_o` = !`hold_ctrl_i[3]` & (`is_store` | `outst` < `MAX_OUT`).
  - `mem_addr_o` = `addr`; `mem_we_o` = `is_store`.
  - The request, address and data stay stable until `mem_gnt_i` is high. Dropping `mem_req_o` under hold or throttle is permitted before grant.
- On a grant (`mem_req_o` & `mem_gnt_i`):
  - `addr` += `stride`, wrapping modulo 2^`ADDR_W`.
  - `issued`++.
  - For a load, `outst`++. For a store, `st_data_pop_o` = 1.
- On the last grant (`issued` == `nbeats`−1): a store goes to DONE; a load goes to DRAIN.
- Load response: when `mem_rvalid_i` is high in ISSUE or DRAIN of a load op:
  - `vrf_we_o` = 1, `vrf_idx_o` = `resp`, `vrf_wdata_o` = `mem_rdata_i`.
  - `resp`++ and `outst`−−.
  - A grant and a response in the same cycle leave `outst` unchanged.
- DRAIN goes to DONE when `outst` reaches 0 (checked on the updated value). A response in IDLE, DONE or any store op is ignored: `vrf_we_o` = 0.
- DONE: `done_o` = 1, then IDLE.
- `hold_req_o`, decoded from the state register:
  - [0] = [1] = (state != IDLE).
  - [2] = load op & state ∈ {ISSUE, DRAIN}, because the VRF write port is owned.
  - [3] = 0 (reserved).
- `issue_ready_o` = (state == IDLE).
- `hold_ctrl_i[3]` freezes issue only. Responses and draining continue. `hold_ctrl_i[2:0]` are ignored.

## Timing
- Reset (`rstn` = 0 at an edge) forces the following, including mid-operation:
  - state = IDLE and all counters = 0.
  - All outputs 0 except `issue_ready_o` = 1.
  - Responses to beats issued before the reset are dropped.
- Accept at edge N:
  - `hold_req_o` = 4'b0011 (store) or 4'b0111 (load) from cycle N+1.
  - The first `mem_req_o` is in cycle N+1 with `mem_addr_o` = base.
- With grant every cycle and no hold:
  - A store of k beats has `done_o` in cycle N+k+1 and `issue_ready_o` in N+k+2.
  - A load finishes one cycle after the cycle in which its last response arrives.
- `nbeats` = 0: `done_o` in N+1, no memory traffic.
- VRF writes are combinational from `mem_rvalid_i`, with zero added latency.

## Test plan
- Store: base=0x100, stride=4, nbeats=3, grant every cycle.
  - Addresses 0x100, 0x104, 0x108; three pops.
  - `done_o` in cycle 4; `hold_req_o` = 0011 in cycles 1–4.
- Load: nbeats=6, MAX_OUT=4, rvalid 3 cycles after each grant.
  - `mem_req_o` drops at `outst` = 4.
  - `vrf_idx_o` runs 0..5 in order; `hold_req_o`[2] is high until DRAIN exits.
- `hold_ctrl_i[3]` pulsed for 2 cycles mid-load.
  - No grants while high; `addr` is frozen; responses are still written.
  - Total beats = 6.
- Stride 0xFFFFFFFC, base=0x4, nbeats=3: addresses 0x4, 0x0, 0xFFFFFFFC.
- nbeats=0: `done_o` one cycle after accept; no `mem_req_o`; `hold_req_o` = 0011 for one cycle.
- `rstn` low during DRAIN with 2 responses pending.
  - Next cycle is IDLE with outputs at reset values.
  - The late `mem_rvalid_i` produces no `vrf_we_o`.
